rgb_axis_packer: RTL and testbench

//  Packs the 24-bit RGB pixel stream from the fractal pixel engine (top) into a 32-bit AXI4-Stream

---
 rtl/rgb_axis_packer_pkg.sv | 36 +++
 rtl/rgb_axis_packer_out_reg.sv | 37 +++
 rtl/rgb_axis_packer.sv | 140 ++++++++++++++
 tb/tb_rgb_axis_packer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_axis_packer_pkg.sv
// rgb_axis_packer_pkg
//   Shared widths, state encoding, tkeep constants and the output word type
//   used by the RGB-to-AXI4-Stream packer and its output register.
package rgb_axis_packer_pkg;

  localparam int PIX_W  = 24;
  localparam int AXIS_W = 32;
  localparam int KEEP_W = AXIS_W / 8;

  typedef enum logic {
    PACK  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [KEEP_W-1:0] KEEP_ALL = 4'b1111;
  localparam logic [KEEP_W-1:0] KEEP_3B  = 4'b0111;
  localparam logic [KEEP_W-1:0] KEEP_2B  = 4'b0011;
  localparam logic [KEEP_W-1:0] KEEP_1B  = 4'b0001;

  typedef struct packed {
    logic [AXIS_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              user;
  } axis_word_t;

  // Residual byte count is encoded by phase: phase 1/2/3 leaves 3/2/1 bytes.
  function automatic logic [KEEP_W-1:0] flush_keep(input logic [1:0] phase);
    case (phase)
      2'd1:    flush_keep = KEEP_3B;
      2'd2:    flush_keep = KEEP_2B;
      default: flush_keep = KEEP_1B;
    endcase
  endfunction

endpackage

// File: rtl/rgb_axis_packer_out_reg.sv
// rgb_axis_packer_out_reg
//   One-deep AXI4-Stream output register. A loaded word is held stable while
//   tvalid & ~tready; the slot is free when ~tvalid | tready.
// Ports
//   clk, reset    : clock, synchronous active-high reset
//   load, wr_word : write a new word (caller only loads when slot_free)
//   tready        : downstream ready
//   word, tvalid  : registered output word and valid
//   slot_free     : register may accept a word this cycle
module rgb_axis_packer_out_reg
  import rgb_axis_packer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  axis_word_t wr_word,
  input  logic       tready,
  output axis_word_t word,
  output logic       tvalid,
  output logic       slot_free
);

  assign slot_free = ~tvalid | tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      word   <= '0;
      tvalid <= 1'b0;
    end else if (load) begin
      word   <= wr_word;
      tvalid <= 1'b1;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/rgb_axis_packer.sv
// rgb_axis_packer
//   Packs 24-bit RGB pixels into a byte-dense little-endian 32-bit AXI4-Stream
//   (4 pixels -> 3 words). tuser marks the first word of a frame, tlast the
//   last word of a line; partial words at line end are flushed with PAD_BYTE.
// Ports
//   clk, reset                     : clock, synchronous active-high reset
//   in_r/in_g/in_b, in_valid       : pixel input
//   in_sof, in_eol, in_ready       : frame/line markers, input handshake
//   out_stream_t*                  : AXI4-Stream master
//   err_misalign                   : sticky, sof seen mid-group
module rgb_axis_packer
  import rgb_axis_packer_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE  = 8'h00,
  parameter int         RGB_ORDER = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_r,
  input  logic [7:0]        in_g,
  input  logic [7:0]        in_b,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_eol,
  output logic              in_ready,
  output logic [AXIS_W-1:0] out_stream_tdata,
  output logic [KEEP_W-1:0] out_stream_tkeep,
  output logic              out_stream_tlast,
  output logic              out_stream_tuser,
  output logic              out_stream_tvalid,
  input  logic              out_stream_tready,
  output logic              err_misalign
);

  state_e           state;
  logic [1:0]       phase;
  logic [PIX_W-1:0] residual;
  logic             sof_pend;
  logic             err;

  logic [PIX_W-1:0] pix;
  logic [1:0]       eph;
  logic             acc, slot_free, load;
  axis_word_t       wr_word, word;

  assign pix = (RGB_ORDER != 0) ? {in_r, in_g, in_b} : {in_b, in_g, in_r};

  // Phase 0 never emits, so a pixel is taken there even under back-pressure.
  assign in_ready = ~reset & (state == PACK) & ((phase == 2'd0) | slot_free);
  assign acc      = in_valid & in_ready;
  // A sof pixel always restarts the group as p0, discarding any residual.
  assign eph      = in_sof ? 2'd0 : phase;

  always_comb begin
    load         = 1'b0;
    wr_word      = '0;
    wr_word.user = sof_pend;
    if (state == PACK) begin
      if (acc) begin
        wr_word.keep = KEEP_ALL;
        case (eph)
          2'd1: begin
            load         = 1'b1;
            wr_word.data = {pix[7:0], residual};
          end
          2'd2: begin
            load         = 1'b1;
            wr_word.data = {pix[15:0], residual[15:0]};
          end
          2'd3: begin
            load         = 1'b1;
            wr_word.data = {pix, residual[7:0]};
            wr_word.last = in_eol;
          end
          default: ;
        endcase
      end
    end else if (slot_free) begin
      load         = 1'b1;
      wr_word.keep = flush_keep(phase);
      wr_word.last = 1'b1;
      case (phase)
        2'd1:    wr_word.data = {PAD_BYTE, residual};
        2'd2:    wr_word.data = {PAD_BYTE, PAD_BYTE, residual[15:0]};
        default: wr_word.data = {PAD_BYTE, PAD_BYTE, PAD_BYTE, residual[7:0]};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PACK;
      phase    <= 2'd0;
      residual <= '0;
      sof_pend <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (load) sof_pend <= 1'b0;
      if (state == PACK) begin
        if (acc) begin
          // sof pixels sit at eph 0 and never load, so this cannot race the clear
          if (in_sof) begin
            sof_pend <= 1'b1;
            if (phase != 2'd0) err <= 1'b1;
          end
          case (eph)
            2'd0: begin residual <= pix;                   phase <= 2'd1; end
            2'd1: begin residual <= {8'h00,  pix[23:8]};   phase <= 2'd2; end
            2'd2: begin residual <= {16'h00, pix[23:16]};  phase <= 2'd3; end
            default: begin residual <= '0;                 phase <= 2'd0; end
          endcase
          // phase keeps encoding the residual size while flushing
          if (in_eol && eph != 2'd3) state <= FLUSH;
        end
      end else if (slot_free) begin
        state    <= PACK;
        phase    <= 2'd0;
        residual <= '0;
      end
    end
  end

  rgb_axis_packer_out_reg u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .wr_word   (wr_word),
    .tready    (out_stream_tready),
    .word      (word),
    .tvalid    (out_stream_tvalid),
    .slot_free (slot_free)
  );

  assign out_stream_tdata = word.data;
  assign out_stream_tkeep = word.keep;
  assign out_stream_tlast = word.last;
  assign out_stream_tuser = word.user;
  assign err_misalign     = err;

endmodule

// File: tb/tb_rgb_axis_packer.sv
module tb_rgb_axis_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_r = '0, in_g = '0, in_b = '0;
  logic        in_valid = 1'b0, in_sof = 1'b0, in_eol = 1'b0;
  logic        in_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast, out_stream_tuser, out_stream_tvalid;
  logic        out_stream_tready = 1'b1;
  logic        err_misalign;

  always #5 clk = ~clk;

  rgb_axis_packer dut (
    .clk               (clk),
    .reset             (reset),
    .in_r              (in_r),
    .in_g              (in_g),
    .in_b              (in_b),
    .in_valid          (in_valid),
    .in_sof            (in_sof),
    .in_eol            (in_eol),
    .in_ready          (in_ready),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tlast  (out_stream_tlast),
    .out_stream_tuser  (out_stream_tuser),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tready (out_stream_tready),
    .err_misalign      (err_misalign)
  );

  typedef struct { logic [23:0] pix; logic sof; logic eol; } pix_t;
  typedef struct { logic [31:0] data; logic [3:0] keep; logic last; logic user; } word_t;

  pix_t  pq[$];
  word_t wq[$];

  int          n_tot = 0, n_fail = 0;
  int          cnt_last = 0, cnt_user = 0, words_in_line = 0;
  bit          frame_mode = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tot++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic push_pix(input logic [23:0] p, input logic s, input logic e);
    pix_t x;
    x.pix = p; x.sof = s; x.eol = e;
    pq.push_back(x);
  endtask

  task automatic push_word(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    word_t w;
    w.data = d; w.keep = k; w.last = l; w.user = u;
    wq.push_back(w);
  endtask

  // mode 0: tready=1, 1: tready=0, 2: random tready
  task automatic run(input int max_cyc, input int mode, input bit until_idle);
    int    c;
    word_t e;
    c = 0;
    while (c < max_cyc && !(until_idle && pq.size() == 0 && wq.size() == 0)) begin
      @(negedge clk);
      out_stream_tready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      if (pq.size() != 0) begin
        in_valid = 1'b1;
        {in_r, in_g, in_b} = pq[0].pix;
        in_sof = pq[0].sof;
        in_eol = pq[0].eol;
      end else begin
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
      end
      #1;
      if (prev_stall) begin
        chk("hold_valid", 32'(out_stream_tvalid), 32'd1);
        chk("hold_data", out_stream_tdata, prev_data);
      end
      prev_stall = out_stream_tvalid & ~out_stream_tready;
      prev_data  = out_stream_tdata;
      if (out_stream_tvalid && out_stream_tready) begin
        if (wq.size() == 0) begin
          chk("unexpected_word", out_stream_tdata, 32'hxxxx_xxxx);
        end else begin
          e = wq.pop_front();
          chk("tdata", out_stream_tdata, e.data);
          chk("tkeep", 32'(out_stream_tkeep), 32'(e.keep));
          chk("tlast", 32'(out_stream_tlast), 32'(e.last));
          chk("tuser", 32'(out_stream_tuser), 32'(e.user));
        end
        if (out_stream_tuser) cnt_user++;
        words_in_line++;
        if (out_stream_tlast) begin
          cnt_last++;
          if (frame_mode) chk("words_per_line", 32'(words_in_line), 32'd480);
          words_in_line = 0;
        end
      end
      if (in_valid && in_ready) void'(pq.pop_front());
      c++;
    end
    if (until_idle) chk("drain_timeout", 32'(pq.size() + wq.size()), 32'd0);
  endtask

  initial begin
    logic [7:0]  bq[$];
    logic [23:0] p;
    bit          first;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_tvalid", 32'(out_stream_tvalid), 32'd0);
    chk("rst_tdata",  out_stream_tdata, 32'd0);
    chk("rst_tkeep",  32'(out_stream_tkeep), 32'd0);
    chk("rst_tlast",  32'(out_stream_tlast), 32'd0);
    chk("rst_tuser",  32'(out_stream_tuser), 32'd0);
    chk("rst_err",    32'(err_misalign), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1 chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // 1: one full group, eol on the 4th pixel
    push_pix(24'h112233, 0, 0); push_pix(24'h445566, 0, 0);
    push_pix(24'h778899, 0, 0); push_pix(24'hAABBCC, 0, 1);
    push_word(32'h66112233, 4'hF, 0, 0);
    push_word(32'h88994455, 4'hF, 0, 0);
    push_word(32'hAABBCC77, 4'hF, 1, 0);
    run(50, 0, 1);

    // 2: single pixel with sof & eol -> flush word
    @(negedge clk);
    out_stream_tready = 1'b1; in_valid = 1'b1;
    {in_r, in_g, in_b} = 24'h112233; in_sof = 1'b1; in_eol = 1'b1;
    #1 chk("t2_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    #1 chk("t2_flush_in_ready", 32'(in_ready), 32'd0);
    chk("t2_flush_tvalid", 32'(out_stream_tvalid), 32'd0);
    @(negedge clk); #1;
    chk("t2_tvalid", 32'(out_stream_tvalid), 32'd1);
    chk("t2_tdata",  out_stream_tdata, 32'h00112233);
    chk("t2_tkeep",  32'(out_stream_tkeep), 32'h7);
    chk("t2_tlast",  32'(out_stream_tlast), 32'd1);
    chk("t2_tuser",  32'(out_stream_tuser), 32'd1);
    @(negedge clk); #1;
    chk("t2_consumed", 32'(out_stream_tvalid), 32'd0);
    chk("t2_ready_back", 32'(in_ready), 32'd1);

    // 3: five pixels, eol on the 5th -> 3 words + 3-byte flush
    push_pix(24'h112233, 0, 0); push_pix(24'h445566, 0, 0);
    push_pix(24'h778899, 0, 0); push_pix(24'h010203, 0, 0);
    push_pix(24'hAABBCC, 0, 1);
    push_word(32'h66112233, 4'hF, 0, 0);
    push_word(32'h88994455, 4'hF, 0, 0);
    push_word(32'h01020377, 4'hF, 0, 0);
    push_word(32'h00AABBCC, 4'h7, 1, 0);
    run(50, 0, 1);

    // 4: back-pressure for 5 cycles mid-line
    push_pix(24'h102030, 0, 0); push_pix(24'h405060, 0, 0);
    push_pix(24'h708090, 0, 0); push_pix(24'hA0B0C0, 0, 1);
    push_word(32'h60102030, 4'hF, 0, 0);
    push_word(32'h80904050, 4'hF, 0, 0);
    push_word(32'hA0B0C070, 4'hF, 1, 0);
    run(5, 1, 0);
    @(negedge clk);
    out_stream_tready = 1'b0; #1;
    chk("t4_in_ready_low", 32'(in_ready), 32'd0);
    chk("t4_tvalid", 32'(out_stream_tvalid), 32'd1);
    chk("t4_tdata_held", out_stream_tdata, 32'h60102030);
    chk("t4_pixels_taken", 32'(pq.size()), 32'd2);
    run(50, 0, 1);

    // 6: sof at phase 2 drops residual and restarts the group
    push_pix(24'h0A0B0C, 1, 0); push_pix(24'h1A1B1C, 0, 0);
    push_pix(24'h2A2B2C, 1, 0); push_pix(24'h3A3B3C, 0, 0);
    push_pix(24'h4A4B4C, 0, 0); push_pix(24'h5A5B5C, 0, 1);
    push_word(32'h1C0A0B0C, 4'hF, 0, 1);
    push_word(32'h3C2A2B2C, 4'hF, 0, 1);
    push_word(32'h4B4C3A3B, 4'hF, 0, 0);
    push_word(32'h5A5B5C4A, 4'hF, 1, 0);
    run(50, 0, 1);
    @(negedge clk); #1;
    chk("t6_err", 32'(err_misalign), 32'd1);

    // reset pulse mid-line with a word pending
    @(negedge clk);
    out_stream_tready = 1'b1; in_valid = 1'b1;
    {in_r, in_g, in_b} = 24'h111111;
    @(negedge clk);
    {in_r, in_g, in_b} = 24'h222222;
    @(negedge clk);
    in_valid = 1'b0; #1;
    chk("t6_word_pending", 32'(out_stream_tvalid), 32'd1);
    reset = 1'b1; #1;
    chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); #1;
    chk("t6_rst_tvalid", 32'(out_stream_tvalid), 32'd0);
    chk("t6_rst_tdata",  out_stream_tdata, 32'd0);
    chk("t6_rst_tkeep",  32'(out_stream_tkeep), 32'd0);
    chk("t6_rst_tlast",  32'(out_stream_tlast), 32'd0);
    chk("t6_rst_tuser",  32'(out_stream_tuser), 32'd0);
    chk("t6_rst_err",    32'(err_misalign), 32'd0);
    reset = 1'b0;
    prev_stall = 1'b0;

    // 5: 640-wide frame (16 lines keeps the run short), random tready.
    // Expected words come from a plain byte-stream model.
    cnt_last = 0; cnt_user = 0; words_in_line = 0; frame_mode = 1'b1;
    first = 1'b1;
    for (int l = 0; l < 16; l++) begin
      for (int i = 0; i < 640; i++) begin
        p = 24'($urandom);
        push_pix(p, (l == 0 && i == 0), (i == 639));
        bq.push_back(p[7:0]); bq.push_back(p[15:8]); bq.push_back(p[23:16]);
      end
      for (int w = 0; w < 480; w++) begin
        logic [31:0] d;
        for (int b = 0; b < 4; b++) d[b*8 +: 8] = bq.pop_front();
        push_word(d, 4'hF, (w == 479), first);
        first = 1'b0;
      end
    end
    run(60000, 2, 1);
    chk("t5_tlast_count", 32'(cnt_last), 32'd16);
    chk("t5_tuser_count", 32'(cnt_user), 32'd1);
    chk("t5_err", 32'(err_misalign), 32'd0);

    $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
    $finish;
  end

endmodule
